sudoku_board_reader: RTL and testbench

Read-side counterpart to the board-entry path (restart/enter/insert with cell_in/val_in).
- Writing: cells are entered one at a time.
- Reading: this block snapshots the 16-cell 4x4 user board on request and streams it out cell by cell over a valid/ready handshake to a display/serial sink.
- While streaming, it accumulates a fill count and detects duplicate digits within rows, columns and 2x2 boxes, giving an independent solved/conflict verdict for the top-level check path.

---
 rtl/sudoku_board_reader.sv | 170 +++++++++++++++++
 tb/tb_sudoku_board_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_board_reader.sv
// ============================================================================
//  Module      : sudoku_board_reader
//  Description : Snapshots a 4x4 Sudoku board and streams it cell by cell over
//                valid/ready while tracking fill count, duplicates and verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sudoku_board_reader #(
    parameter int VAL_W     = 3,
    parameter int MAX_DIGIT = 4
) (
    input  logic                 in_clka,
    input  logic                 in_restart,
    input  logic                 in_start,
    input  logic [16*VAL_W-1:0]  in_board,
    input  logic                 in_ready,
    output logic                 out_valid,
    output logic [3:0]           out_cell_idx,
    output logic [VAL_W-1:0]     out_cell_val,
    output logic                 out_last,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [4:0]           out_filled_count,
    output logic                 out_conflict,
    output logic                 out_bad_val,
    output logic                 out_solved
);

    localparam logic [VAL_W-1:0] C_MAX_VAL = VAL_W'(MAX_DIGIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [16*VAL_W-1:0]   r_snap;
    logic [3:0]            r_idx;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [4:0]            r_filled;
    logic                  r_conflict;
    logic                  r_bad;
    logic                  r_solved;
    logic [MAX_DIGIT-1:0]  r_row_seen [4];
    logic [MAX_DIGIT-1:0]  r_col_seen [4];
    logic [MAX_DIGIT-1:0]  r_box_seen [4];

    logic                  w_xfer;
    logic [VAL_W-1:0]      w_cur_val;
    logic [1:0]            w_row;
    logic [1:0]            w_col;
    logic [1:0]            w_box;
    logic [MAX_DIGIT-1:0]  w_onehot;
    logic                  w_legal;
    logic                  w_illegal;
    logic                  w_dup;
    logic [4:0]            w_next_filled;
    logic                  w_next_conflict;
    logic                  w_next_bad;

    assign w_xfer    = r_valid & in_ready;
    assign w_cur_val = r_snap[VAL_W*r_idx +: VAL_W];
    assign w_row     = r_idx[3:2];
    assign w_col     = r_idx[1:0];
    assign w_box     = {r_idx[3], r_idx[1]};

    generate
        for (genvar k = 0; k < MAX_DIGIT; k++) begin : g_onehot
            assign w_onehot[k] = (w_cur_val == VAL_W'(k + 1));
        end
    endgenerate

    assign w_legal   = (w_cur_val != '0) && (w_cur_val <= C_MAX_VAL);
    assign w_illegal = (w_cur_val > C_MAX_VAL);
    assign w_dup     = |(w_onehot & (r_row_seen[w_row] | r_col_seen[w_col] | r_box_seen[w_box]));

    // Post-transfer values, so the verdict can be registered alongside out_done
    assign w_next_filled   = (w_xfer && w_legal) ? r_filled + 5'd1 : r_filled;
    assign w_next_conflict = r_conflict | (w_xfer & w_legal & w_dup);
    assign w_next_bad      = r_bad | (w_xfer & w_illegal);

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_state    <= ST_IDLE;
            r_snap     <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_filled   <= '0;
            r_conflict <= 1'b0;
            r_bad      <= 1'b0;
            r_solved   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_row_seen[i] <= '0;
                r_col_seen[i] <= '0;
                r_box_seen[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_start) begin
                        r_snap     <= in_board;
                        r_idx      <= '0;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_filled   <= '0;
                        r_conflict <= 1'b0;
                        r_bad      <= 1'b0;
                        r_solved   <= 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            r_row_seen[i] <= '0;
                            r_col_seen[i] <= '0;
                            r_box_seen[i] <= '0;
                        end
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_row_seen[w_row] <= r_row_seen[w_row] | w_onehot;
                            r_col_seen[w_col] <= r_col_seen[w_col] | w_onehot;
                            r_box_seen[w_box] <= r_box_seen[w_box] | w_onehot;
                        end
                        r_filled   <= w_next_filled;
                        r_conflict <= w_next_conflict;
                        r_bad      <= w_next_bad;
                        if (r_idx == 4'd15) begin
                            r_valid  <= 1'b0;
                            r_done   <= 1'b1;
                            r_solved <= (w_next_filled == 5'd16) && !w_next_conflict && !w_next_bad;
                            r_state  <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid        = r_valid;
    assign out_cell_idx     = r_idx;
    assign out_cell_val     = w_cur_val;
    assign out_last         = r_valid && (r_idx == 4'd15);
    assign out_busy         = r_busy;
    assign out_done         = r_done;
    assign out_filled_count = r_filled;
    assign out_conflict     = r_conflict;
    assign out_bad_val      = r_bad;
    assign out_solved       = r_solved;

endmodule

`default_nettype wire

// File: tb/tb_sudoku_board_reader.sv
// ============================================================================
//  Module      : tb_sudoku_board_reader
//  Description : Directed self-checking bench for sudoku_board_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sudoku_board_reader;

    logic        in_clka = 1'b0;
    logic        in_restart;
    logic        in_start;
    logic [47:0] in_board;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_cell_idx;
    logic [2:0]  out_cell_val;
    logic        out_last;
    logic        out_busy;
    logic        out_done;
    logic [4:0]  out_filled_count;
    logic        out_conflict;
    logic        out_bad_val;
    logic        out_solved;

    int n_tests = 0;
    int n_fail  = 0;

    sudoku_board_reader #(.VAL_W(3), .MAX_DIGIT(4)) u_dut (
        .in_clka          (in_clka),
        .in_restart       (in_restart),
        .in_start         (in_start),
        .in_board         (in_board),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_cell_idx     (out_cell_idx),
        .out_cell_val     (out_cell_val),
        .out_last         (out_last),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_filled_count (out_filled_count),
        .out_conflict     (out_conflict),
        .out_bad_val      (out_bad_val),
        .out_solved       (out_solved)
    );

    always #5 in_clka = ~in_clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Board written as 16 hex digits, first digit is cell 0 (row-major)
    function automatic logic [2:0] nib_at(input logic [63:0] h, input int i);
        logic [3:0] n;
        n = h[63-4*i -: 4];
        return n[2:0];
    endfunction

    function automatic logic [47:0] pack(input logic [63:0] h);
        logic [47:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[3*i +: 3] = nib_at(h, i);
        return b;
    endfunction

    task automatic tick();
        @(posedge in_clka);
        #1;
    endtask

    task automatic do_pass(input logic [63:0] h, input bit bp, input int conf_idx,
                           input logic [4:0] e_filled, input bit e_conf,
                           input bit e_bad, input bit e_solved);
        logic [47:0] b;
        logic [5:0]  pat;
        int          nx;
        bit          rdy;
        bit          got_done;
        b        = pack(h);
        pat      = 6'b101001;
        nx       = 0;
        got_done = 1'b0;
        in_board = b;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        check("first_valid", out_valid, 1);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (out_done) begin
                got_done = 1'b1;
                if (!bp) check("done_latency", cyc, 16);
                check("xfer_count", nx, 16);
                check("done_valid", out_valid, 0);
                check("filled", out_filled_count, e_filled);
                check("conflict", out_conflict, e_conf);
                check("bad_val", out_bad_val, e_bad);
                check("solved", out_solved, e_solved);
                break;
            end
            if (out_valid) begin
                check("idx", out_cell_idx, nx);
                check("val", out_cell_val, nib_at(h, nx));
                check("last", out_last, nx == 15);
                check("conf_live", out_conflict, nx > conf_idx);
                check("busy_send", out_busy, 1);
            end
            rdy = bp ? pat[cyc % 6] : 1'b1;
            if (bp && cyc == 3) in_board = ~b;
            in_ready = rdy;
            if (out_valid && rdy) nx++;
            tick();
        end
        if (!got_done) begin
            check("done_timeout", 0, 1);
        end else begin
            tick();
            check("done_pulse", out_done, 0);
            check("busy_idle", out_busy, 0);
            check("hold_filled", out_filled_count, e_filled);
            check("hold_solved", out_solved, e_solved);
        end
    endtask

    initial begin
        int ndone;
        in_restart = 1'b1;
        in_start   = 1'b0;
        in_board   = '0;
        in_ready   = 1'b0;
        tick();
        tick();
        in_restart = 1'b0;
        check("rst_valid", out_valid, 0);
        check("rst_busy", out_busy, 0);
        check("rst_done", out_done, 0);
        check("rst_idx", out_cell_idx, 0);
        check("rst_val", out_cell_val, 0);
        check("rst_flags", {out_last, out_conflict, out_bad_val, out_solved}, 0);
        check("rst_filled", out_filled_count, 0);

        // Solved board, empty board, duplicate in box 0, backpressure, illegal value
        do_pass(64'h1234_3412_2143_4321, 1'b0, 16, 5'd16, 1'b0, 1'b0, 1'b1);
        do_pass(64'h0000_0000_0000_0000, 1'b0, 16, 5'd0,  1'b0, 1'b0, 1'b0);
        do_pass(64'h1000_0100_0000_0000, 1'b0, 5,  5'd2,  1'b1, 1'b0, 1'b0);
        do_pass(64'h4321_2143_3412_1234, 1'b1, 16, 5'd16, 1'b0, 1'b0, 1'b1);
        do_pass(64'h1234_3412_2173_4321, 1'b0, 16, 5'd15, 1'b0, 1'b1, 1'b0);

        // Restart mid-stream at idx 8
        in_board = pack(64'h1234_3412_2143_4321);
        in_ready = 1'b1;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        for (int i = 0; i < 40 && out_cell_idx != 4'd8; i++) tick();
        check("pre_restart_idx", out_cell_idx, 8);
        check("pre_restart_filled", out_filled_count, 8);
        in_restart = 1'b1;
        tick();
        in_restart = 1'b0;
        check("rs_valid", out_valid, 0);
        check("rs_busy", out_busy, 0);
        check("rs_idx", out_cell_idx, 0);
        check("rs_val", out_cell_val, 0);
        check("rs_filled", out_filled_count, 0);
        check("rs_flags", {out_last, out_conflict, out_bad_val, out_solved}, 0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_done) ndone++;
            tick();
        end
        check("rs_no_done", ndone, 0);

        // A start request during SEND must not restart the pass
        in_board = pack(64'h1234_3412_2143_4321);
        in_ready = 1'b1;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_ign_idx", out_cell_idx, 3);
        in_board = '0;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        check("ign_idx", out_cell_idx, 4);
        check("ign_val", out_cell_val, 3);
        ndone = 0;
        for (int i = 0; i < 40 && ndone == 0; i++) begin
            if (out_done) ndone++;
            else tick();
        end
        check("ign_done", ndone, 1);
        check("ign_solved", out_solved, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
